// File: rtl/sum_engine_pkg.sv
// rtl/sum_engine_pkg.sv - shared types and width helpers for the line-sum engine
// Contents: t_sum_state (job FSM states), ELEMS_PER_LINE for the default line
// geometry, and constant functions that size per-instance datapaths.
package sum_engine_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        READ    = 3'd1,
        DRAIN   = 3'd2,
        WRITE   = 3'd3,
        WAIT_WR = 3'd4
    } t_sum_state;

    localparam int DEFAULT_DATA_W = 512;
    localparam int DEFAULT_ELEM_W = 8;
    localparam int ELEMS_PER_LINE = DEFAULT_DATA_W / DEFAULT_ELEM_W;

    function automatic int elems_per_line(input int data_w, input int elem_w);
        return data_w / elem_w;
    endfunction

    // Line sums are kept wide enough to never lose a carry, and at least as
    // wide as the accumulator so the carry out of ACC_W is always visible.
    function automatic int line_sum_w(input int data_w, input int elem_w, input int acc_w);
        int s;
        s = elem_w + $clog2(data_w / elem_w);
        return (s > acc_w) ? s : acc_w;
    endfunction

endpackage

// File: rtl/line_reducer.sv
// rtl/line_reducer.sv - one-stage unsigned horizontal sum of a cache line
// Ports: clk, reset_n (sync, active-low); in_valid/in_data (one line);
// out_valid/out_sum (sum of all ELEM_W elements, registered one cycle).
module line_reducer
    import sum_engine_pkg::*;
#(
    parameter int DATA_W = 512,
    parameter int ELEM_W = 8,
    parameter int ACC_W  = 32,
    localparam int SUM_W = line_sum_w(DATA_W, ELEM_W, ACC_W)
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    output logic [SUM_W-1:0]  out_sum
);

    localparam int N_ELEMS = elems_per_line(DATA_W, ELEM_W);

    logic             valid_q, valid_d;
    logic [SUM_W-1:0] sum_q, sum_d;

    always_comb begin
        valid_d = in_valid;
        sum_d   = '0;
        for (int i = 0; i < N_ELEMS; i++) begin
            sum_d = sum_d + SUM_W'(in_data[i*ELEM_W +: ELEM_W]);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            valid_q <= 1'b0;
            sum_q   <= '0;
        end else begin
            valid_q <= valid_d;
            sum_q   <= sum_d;
        end
    end

    assign out_valid = valid_q;
    assign out_sum   = sum_q;

endmodule

// File: rtl/sum_engine.sv
// rtl/sum_engine.sv - reads num_lines cache lines, sums every element, writes the total
// Ports: clk, reset_n (sync, active-low); start/src_addr/dst_addr/num_lines job
// setup; rd_req_* / rd_almfull read requests; rd_rsp_* read data (any order);
// wr_req_* / wr_almfull result write; wr_rsp_valid write completion;
// busy, done (pulse on completion), overflow (carry out of the accumulator).
module sum_engine
    import sum_engine_pkg::*;
#(
    parameter int ADDR_W          = 42,
    parameter int DATA_W          = 512,
    parameter int ELEM_W          = 8,
    parameter int ACC_W           = 32,
    parameter int LEN_W           = 16,
    parameter int MAX_OUTSTANDING = 8
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] src_addr,
    input  logic [ADDR_W-1:0] dst_addr,
    input  logic [LEN_W-1:0]  num_lines,
    output logic              rd_req_valid,
    output logic [ADDR_W-1:0] rd_req_addr,
    input  logic              rd_almfull,
    input  logic              rd_rsp_valid,
    input  logic [DATA_W-1:0] rd_rsp_data,
    output logic              wr_req_valid,
    output logic [ADDR_W-1:0] wr_req_addr,
    output logic [DATA_W-1:0] wr_req_data,
    input  logic              wr_almfull,
    input  logic              wr_rsp_valid,
    output logic              busy,
    output logic              done,
    output logic              overflow
);

    localparam int SUM_W = line_sum_w(DATA_W, ELEM_W, ACC_W);
    localparam int OUT_W = $clog2(MAX_OUTSTANDING + 1);
    localparam logic [OUT_W-1:0] MAX_OUT = OUT_W'(MAX_OUTSTANDING);

    t_sum_state        state_q, state_d;
    logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
    logic [ADDR_W-1:0] dst_q, dst_d;
    logic [LEN_W-1:0]  len_q, len_d;
    logic [LEN_W-1:0]  issued_q, issued_d;
    logic [LEN_W-1:0]  received_q, received_d;
    logic [OUT_W-1:0]  outst_q, outst_d;
    logic [ACC_W-1:0]  acc_q, acc_d;
    logic              ovf_q, ovf_d;
    logic              rd_req_valid_q, rd_req_valid_d;
    logic [ADDR_W-1:0] rd_req_addr_q, rd_req_addr_d;
    logic              wr_req_valid_q, wr_req_valid_d;

    logic              rsp_accept;
    logic              issue;
    logic              red_valid;
    logic [SUM_W-1:0]  red_sum;
    logic [SUM_W:0]    acc_wide;

    // Responses only count while a job is collecting data; stale ones after
    // a reset or in IDLE fall on the floor.
    assign rsp_accept = rd_rsp_valid && ((state_q == READ) || (state_q == DRAIN));

    line_reducer #(
        .DATA_W (DATA_W),
        .ELEM_W (ELEM_W),
        .ACC_W  (ACC_W)
    ) u_line_reducer (
        .clk       (clk),
        .reset_n   (reset_n),
        .in_valid  (rsp_accept),
        .in_data   (rd_rsp_data),
        .out_valid (red_valid),
        .out_sum   (red_sum)
    );

    always_comb begin
        state_d        = state_q;
        rd_addr_d      = rd_addr_q;
        dst_d          = dst_q;
        len_d          = len_q;
        issued_d       = issued_q;
        received_d     = received_q;
        outst_d        = outst_q;
        acc_d          = acc_q;
        ovf_d          = ovf_q;
        rd_req_valid_d = 1'b0;
        rd_req_addr_d  = rd_req_addr_q;
        wr_req_valid_d = 1'b0;
        issue          = 1'b0;

        // Any bit above ACC_W in the widened add is a carry out of the accumulator.
        acc_wide = (SUM_W+1)'(acc_q) + (SUM_W+1)'(red_sum);
        if (red_valid) begin
            acc_d = acc_wide[ACC_W-1:0];
            ovf_d = ovf_q | (|acc_wide[SUM_W:ACC_W]);
        end
        if (rsp_accept) begin
            received_d = received_q + LEN_W'(1);
        end

        case (state_q)
            IDLE: begin
                if (start) begin
                    rd_addr_d  = src_addr;
                    dst_d      = dst_addr;
                    len_d      = num_lines;
                    issued_d   = '0;
                    received_d = '0;
                    outst_d    = '0;
                    acc_d      = '0;
                    ovf_d      = 1'b0;
                    state_d    = (num_lines == '0) ? WRITE : READ;
                end
            end
            READ: begin
                if (!rd_almfull && (outst_q < MAX_OUT)) begin
                    issue          = 1'b1;
                    rd_req_valid_d = 1'b1;
                    rd_req_addr_d  = rd_addr_q;
                    rd_addr_d      = rd_addr_q + ADDR_W'(1);
                    issued_d       = issued_q + LEN_W'(1);
                    if (issued_q == len_q - LEN_W'(1)) begin
                        state_d = DRAIN;
                    end
                end
            end
            DRAIN: begin
                // The last line sum must have left the reducer before the write.
                if ((received_q == len_q) && !red_valid) begin
                    state_d = WRITE;
                end
            end
            WRITE: begin
                if (!wr_almfull) begin
                    wr_req_valid_d = 1'b1;
                    state_d        = WAIT_WR;
                end
            end
            WAIT_WR: begin
                if (wr_rsp_valid) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        case ({issue, rsp_accept && (outst_q != '0)})
            2'b10:   outst_d = outst_q + OUT_W'(1);
            2'b01:   outst_d = outst_q - OUT_W'(1);
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q        <= IDLE;
            rd_addr_q      <= '0;
            dst_q          <= '0;
            len_q          <= '0;
            issued_q       <= '0;
            received_q     <= '0;
            outst_q        <= '0;
            acc_q          <= '0;
            ovf_q          <= 1'b0;
            rd_req_valid_q <= 1'b0;
            rd_req_addr_q  <= '0;
            wr_req_valid_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            rd_addr_q      <= rd_addr_d;
            dst_q          <= dst_d;
            len_q          <= len_d;
            issued_q       <= issued_d;
            received_q     <= received_d;
            outst_q        <= outst_d;
            acc_q          <= acc_d;
            ovf_q          <= ovf_d;
            rd_req_valid_q <= rd_req_valid_d;
            rd_req_addr_q  <= rd_req_addr_d;
            wr_req_valid_q <= wr_req_valid_d;
        end
    end

    always_comb begin
        wr_req_data            = '0;
        wr_req_data[ACC_W-1:0] = acc_q;
        wr_req_data[ACC_W]     = ovf_q;
    end

    assign rd_req_valid = rd_req_valid_q;
    assign rd_req_addr  = rd_req_addr_q;
    assign wr_req_valid = wr_req_valid_q;
    assign wr_req_addr  = dst_q;
    assign busy         = (state_q != IDLE);
    // done marks the completion cycle itself, so it follows wr_rsp_valid directly.
    assign done         = reset_n && (state_q == WAIT_WR) && wr_rsp_valid;
    assign overflow     = ovf_q;

endmodule

// File: tb/tb_sum_engine.sv
// tb/tb_sum_engine.sv - directed self-checking bench for sum_engine
module tb_sum_engine;

    localparam int AW = 42;
    localparam int DW = 512;
    localparam int LW = 16;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          start = 1'b0;
    logic          start8 = 1'b0;
    logic [AW-1:0] src_addr = '0;
    logic [AW-1:0] dst_addr = '0;
    logic [LW-1:0] num_lines = '0;
    logic          rd_almfull = 1'b0;
    logic          rd_rsp_valid = 1'b0;
    logic [DW-1:0] rd_rsp_data = '0;
    logic          wr_almfull = 1'b0;
    logic          wr_rsp_valid = 1'b0;

    logic          rd_req_valid, wr_req_valid, busy, done, overflow;
    logic [AW-1:0] rd_req_addr, wr_req_addr;
    logic [DW-1:0] wr_req_data;
    logic          rd_req_valid8, wr_req_valid8, busy8, done8, overflow8;
    logic [AW-1:0] rd_req_addr8, wr_req_addr8;
    logic [DW-1:0] wr_req_data8;

    sum_engine dut (
        .clk(clk), .reset_n(reset_n), .start(start),
        .src_addr(src_addr), .dst_addr(dst_addr), .num_lines(num_lines),
        .rd_req_valid(rd_req_valid), .rd_req_addr(rd_req_addr), .rd_almfull(rd_almfull),
        .rd_rsp_valid(rd_rsp_valid), .rd_rsp_data(rd_rsp_data),
        .wr_req_valid(wr_req_valid), .wr_req_addr(wr_req_addr), .wr_req_data(wr_req_data),
        .wr_almfull(wr_almfull), .wr_rsp_valid(wr_rsp_valid),
        .busy(busy), .done(done), .overflow(overflow)
    );

    sum_engine #(.ACC_W(8)) dut8 (
        .clk(clk), .reset_n(reset_n), .start(start8),
        .src_addr(src_addr), .dst_addr(dst_addr), .num_lines(num_lines),
        .rd_req_valid(rd_req_valid8), .rd_req_addr(rd_req_addr8), .rd_almfull(rd_almfull),
        .rd_rsp_valid(rd_rsp_valid), .rd_rsp_data(rd_rsp_data),
        .wr_req_valid(wr_req_valid8), .wr_req_addr(wr_req_addr8), .wr_req_data(wr_req_data8),
        .wr_almfull(wr_almfull), .wr_rsp_valid(wr_rsp_valid),
        .busy(busy8), .done(done8), .overflow(overflow8)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int rd_cnt = 0, rsp_seen = 0, rsp_sent = 0, peak = 0, wr_cnt = 0, done_cnt = 0;
    int rd8_cnt = 0, wr8_cnt = 0, done8_cnt = 0;
    logic [DW-1:0] wr_data = '0, wr8_data = '0;
    logic [AW-1:0] wr_addr = '0;
    logic [AW-1:0] rd_log[$];

    always @(negedge clk) begin
        if (rd_req_valid) begin
            rd_cnt++;
            rd_log.push_back(rd_req_addr);
        end
        if (rd_rsp_valid) rsp_seen++;
        if (rd_cnt - rsp_seen > peak) peak = rd_cnt - rsp_seen;
        if (wr_req_valid) begin
            wr_cnt++;
            wr_data = wr_req_data;
            wr_addr = wr_req_addr;
        end
        if (done) done_cnt++;
        if (rd_req_valid8) rd8_cnt++;
        if (wr_req_valid8) begin
            wr8_cnt++;
            wr8_data = wr_req_data8;
        end
        if (done8) done8_cnt++;
    end

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic int rdc(input bit sel);
        return sel ? rd8_cnt : rd_cnt;
    endfunction

    function automatic int wrc(input bit sel);
        return sel ? wr8_cnt : wr_cnt;
    endfunction

    task automatic kick(input bit sel, input logic [AW-1:0] s, input logic [AW-1:0] d, input int n);
        src_addr  = s;
        dst_addr  = d;
        num_lines = LW'(n);
        if (sel) start8 = 1'b1; else start = 1'b1;
        step();
        start  = 1'b0;
        start8 = 1'b0;
    endtask

    task automatic respond(input bit sel, input logic [DW-1:0] d);
        rd_rsp_valid = 1'b1;
        rd_rsp_data  = d;
        step();
        rd_rsp_valid = 1'b0;
        if (!sel) rsp_sent++;
    endtask

    task automatic wait_rd(input bit sel, input int target);
        for (int i = 0; i < 100 && rdc(sel) < target; i++) step();
    endtask

    // Lets requests pile up, then answers the whole pending batch at once.
    task automatic serve(input string tag, input int n, input logic [DW-1:0] d);
        int got = 0;
        int k;
        for (int it = 0; it < 40 && got < n; it++) begin
            repeat (12) step();
            k = rd_cnt - rsp_sent;
            for (int j = 0; j < k; j++) respond(1'b0, d);
            got += k;
        end
        chk({tag, "_lines_served"}, DW'(got), DW'(n));
    endtask

    task automatic finish_job(input bit sel, input string tag);
        int w0 = wrc(sel);
        for (int i = 0; i < 300 && wrc(sel) == w0; i++) step();
        chk({tag, "_write_issued"}, DW'(wrc(sel)), DW'(w0 + 1));
        wr_rsp_valid = 1'b1;
        step();
        wr_rsp_valid = 1'b0;
        step();
    endtask

    initial begin
        logic [DW-1:0] d;
        logic [AW-1:0] s2;
        int r0, w0, c0, dn0;

        // reset state
        repeat (3) step();
        chk("rst_busy", DW'(busy), DW'(0));
        chk("rst_done", DW'(done), DW'(0));
        chk("rst_rd_req_valid", DW'(rd_req_valid), DW'(0));
        chk("rst_wr_req_valid", DW'(wr_req_valid), DW'(0));
        chk("rst_overflow", DW'(overflow), DW'(0));
        reset_n = 1'b1;
        step();

        // basic single-line job: bytes[1]=3, bytes[2]=5 -> 8
        kick(1'b0, AW'(42'h100), AW'(42'h200), 1);
        wait_rd(1'b0, 1);
        chk("t1_rd_count", DW'(rd_cnt), DW'(1));
        chk("t1_rd_addr", DW'(rd_log[0]), DW'(42'h100));
        d = '0;
        d[15:8]  = 8'd3;
        d[23:16] = 8'd5;
        respond(1'b0, d);
        finish_job(1'b0, "t1");
        chk("t1_wr_data", wr_data, DW'(8));
        chk("t1_wr_addr", DW'(wr_addr), DW'(42'h200));
        chk("t1_done_pulses", DW'(done_cnt), DW'(1));
        chk("t1_overflow", DW'(overflow), DW'(0));
        chk("t1_idle", DW'(busy), DW'(0));

        // 20 lines of 0xFF bytes with address wrap; outstanding capped at 8
        s2 = '1;
        s2 = s2 - AW'(4);
        r0 = rd_log.size();
        peak = 0;
        kick(1'b0, s2, AW'(42'h210), 20);
        chk("t2_busy", DW'(busy), DW'(1));
        d = '1;
        serve("t2", 20, d);
        finish_job(1'b0, "t2");
        chk("t2_sum", wr_data, DW'(326400));
        chk("t2_peak_outstanding", DW'(peak), DW'(8));
        chk("t2_rd_count", DW'(rd_log.size() - r0), DW'(20));
        chk("t2_addr_first", DW'(rd_log[r0]), DW'(s2));
        chk("t2_addr_wrap", DW'(rd_log[r0 + 5]), DW'(0));
        chk("t2_addr_last", DW'(rd_log[r0 + 19]), DW'(14));

        // backpressure on both channels: 4 lines of (5 + 16) = 84
        kick(1'b0, AW'(42'h400), AW'(42'h220), 4);
        repeat (2) step();
        rd_almfull = 1'b1;
        step();
        c0 = rd_cnt;
        repeat (9) step();
        chk("t3_no_rd_while_almfull", DW'(rd_cnt), DW'(c0));
        rd_almfull = 1'b0;
        wr_almfull = 1'b1;
        d = '0;
        d[7:0]     = 8'd5;
        d[511:504] = 8'h10;
        w0 = wr_cnt;
        serve("t3", 4, d);
        repeat (8) step();
        chk("t3_no_wr_while_almfull", DW'(wr_cnt), DW'(w0));
        chk("t3_busy_held", DW'(busy), DW'(1));
        wr_almfull = 1'b0;
        finish_job(1'b0, "t3");
        chk("t3_sum", wr_data, DW'(84));

        // zero-length job
        c0  = rd_cnt;
        dn0 = done_cnt;
        kick(1'b0, AW'(42'h500), AW'(42'h230), 0);
        finish_job(1'b0, "t4");
        chk("t4_no_reads", DW'(rd_cnt), DW'(c0));
        chk("t4_wr_data", wr_data, DW'(0));
        chk("t4_done", DW'(done_cnt), DW'(dn0 + 1));

        // reset in DRAIN, stale responses ignored, start ignored while busy
        c0 = rd_cnt;
        w0 = wr_cnt;
        kick(1'b0, AW'(42'h40), AW'(42'h240), 3);
        wait_rd(1'b0, c0 + 3);
        chk("t6_rd_count", DW'(rd_cnt - c0), DW'(3));
        d = '1;
        respond(1'b0, d);
        reset_n = 1'b0;
        step();
        reset_n = 1'b1;
        chk("t6_busy_after_reset", DW'(busy), DW'(0));
        respond(1'b0, d);
        respond(1'b0, d);
        dn0 = done_cnt;
        repeat (10) step();
        chk("t6_no_write", DW'(wr_cnt), DW'(w0));
        chk("t6_still_idle", DW'(busy), DW'(0));
        chk("t6_no_done", DW'(done_cnt), DW'(dn0));
        c0 = rd_cnt;
        kick(1'b0, AW'(42'h80), AW'(42'h300), 2);
        kick(1'b0, AW'(42'h900), AW'(42'h999), 5);
        d = '0;
        d[87:80] = 8'd7;
        serve("t6", 2, d);
        finish_job(1'b0, "t6");
        chk("t6_new_rd_count", DW'(rd_cnt - c0), DW'(2));
        chk("t6_new_wr_addr", DW'(wr_addr), DW'(42'h300));
        chk("t6_new_sum", wr_data, DW'(14));
        chk("t6_new_done", DW'(done_cnt), DW'(dn0 + 1));

        // 8-bit accumulator overflow: 200 + 100 = 300 -> 44 with carry
        kick(1'b1, AW'(42'h600), AW'(42'h250), 1);
        wait_rd(1'b1, 1);
        chk("t5_rd_count", DW'(rd8_cnt), DW'(1));
        d = '0;
        d[7:0]  = 8'd200;
        d[15:8] = 8'd100;
        respond(1'b1, d);
        finish_job(1'b1, "t5");
        chk("t5_sum_low", DW'(wr8_data[7:0]), DW'(44));
        chk("t5_result_bit8", DW'(wr8_data[8]), DW'(1));
        chk("t5_wr_data", wr8_data, DW'(300));
        chk("t5_overflow", DW'(overflow8), DW'(1));
        chk("t5_done", DW'(done8_cnt), DW'(1));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
